updown_range_counter: RTL and testbench
=======================================

# updown_range_counter

Parametrised up/down counter, successor to the basic enable/dec/load counter. Adds programmable step size, programmable lower/upper limits with wrap or saturate mode, and a latched compare reference for the threshold flag. Adds terminal-count and wrap pulses. Used as a general event/position counter and as a timebase in lab datapaths, driven directly from switch/button logic or a controller FSM.

## Interface
- N, 32, counter and limit width
- STEP_W, 8, width of step magnitude input
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  count by `step` this cycle
- dec  in  1  direction: 1 down, 0 up
- load  in  1  load `load_value` into counter
- load_value  in  N  value for load
- step  in  STEP_W  unsigned count increment/decrement magnitude
- limit_lo  in  N  lower bound, inclusive, unsigned
- limit_hi  in  N  upper bound, inclusive, unsigned
- sat_mode  in  1  1 saturate at bounds, 0 wrap within [limit_lo, limit_hi]
- ref_we  in  1  latch `ref_value` into internal compare register
- ref_value  in  N  compare reference
- counterN  out  N  registered count
- threshold  out  1  counterN > ref_reg, combinational from registers
- tc  out  1  registered one-cycle terminal-count flag
- wrapped  out  1  registered one-cycle wrap flag

## Operation
- Update priority per edge: reset > load > enable > hold. Load wins over enable; this differs from the previous counter.
- Reset: counterN=0, ref_reg=0, tc=0, wrapped=0, so threshold=0.
- Load: counterN=load_value, with no clamping to limits. tc=0 and wrapped=0.
- ref_we is independent of the count path. ref_reg updates on any non-reset edge, including the same edge as load or count.
- Invalid range (limit_lo > limit_hi) with enable: counterN holds, tc=0, wrapped=0.
- step=0 with enable: counterN holds. tc=1 if counterN already equals the bound in the count direction; wrapped=0.
- Count up, valid range. Compute sum = counterN + step in N+1 bits.
  - sum ≤ limit_hi: new = sum.
  - sum > limit_hi, sat_mode=1: new = limit_hi.
  - sum > limit_hi, sat_mode=0: new = limit_lo + (sum − limit_hi − 1); wrapped=1. If that result exceeds limit_hi (step larger than the range, or counter above the range), new = limit_lo.
- Count down, valid range. Compute underflow = counterN < limit_lo + step, with the addition done in N+1 bits.
  - No underflow: new = counterN − step.
  - Underflow, sat_mode=1: new = limit_lo.
  - Underflow, sat_mode=0: new = limit_hi − (limit_lo + step − counterN − 1); wrapped=1. If that result falls below limit_lo or the subtraction borrows, new = limit_hi.
- tc=1 on a counting edge when either holds:
  - new equals limit_hi (up) or limit_lo (down);
  - a wrap or saturation occurred.
- While held at a bound in sat_mode with enable=1, tc stays 1 every counting cycle.
- Limits and sat_mode are sampled every cycle and may change at any time; no pipeline state depends on them.

## Timing
- Count, load and ref latch: one-cycle latency. Values are visible on counterN/ref_reg after the edge.
- tc and wrapped are registered on the same edge as the counterN update they describe. They are high for exactly that cycle unless re-triggered.
- threshold has zero added latency relative to counterN/ref_reg; it changes in the same cycle they do.
- Reset asserted mid-count: next edge forces all reset values; the enable/load inputs on that edge are ignored.
- No handshake: every enabled cycle is a count event. Full-rate counting is supported.

## Test plan
- N=8, STEP_W=4. Count up to 37, then assert reset with enable=1 → next cycle counterN=0, tc=0, wrapped=0, threshold=0.
- lo=10, hi=20, sat_mode=0, up, step=2 from 18 → 20, tc=1, wrapped=0. Then step=3 from 18 → 10, tc=1, wrapped=1.
- lo=5, hi=50, sat_mode=1, down, step=4 from 7 → 5, tc=1. The next enabled cycle stays 5 with tc=1 and wrapped=0.
- enable=1, load=1, load_value=200, hi=250 → counterN=200, tc=0. Then up step=1 → 201.
- ref_we with ref_value=100, counting up from 99 by 1 → counterN 100, 101 with threshold 0, 1, switching in the same cycle as counterN.
- lo=30, hi=20, enable=1 from 25 → counterN holds 25, tc=0, wrapped=0 for 4 cycles.

Source files
------------

// File: rtl/updown_range_counter.sv
// Up/down counter with programmable step, inclusive [limit_lo, limit_hi] range,
// wrap or saturate at the bounds, a latched compare reference and tc/wrap pulses.
module updown_range_counter #(
    parameter int N      = 32,
    parameter int STEP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              dec,
    input  logic              load,
    input  logic [N-1:0]      load_value,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      limit_lo,
    input  logic [N-1:0]      limit_hi,
    input  logic              sat_mode,
    input  logic              ref_we,
    input  logic [N-1:0]      ref_value,
    output logic [N-1:0]      counterN,
    output logic              threshold,
    output logic              tc,
    output logic              wrapped
);

    localparam logic [N:0]   ONE_N1 = {{N{1'b0}}, 1'b1};
    localparam logic [N+1:0] ONE_N2 = {{(N+1){1'b0}}, 1'b1};

    logic [N-1:0] ref_reg;
    logic [N-1:0] cnt_next;
    logic         tc_next;
    logic         wrapped_next;

    logic [N:0]   step_ext;
    logic [N:0]   sum_up;
    logic [N:0]   lo_plus_step;
    logic [N:0]   gap_dn;
    logic [N+1:0] wrap_up;
    logic [N+1:0] wrap_dn;
    logic         range_ok;

    // Wide intermediates keep every carry/borrow visible so the bound checks are exact.
    always_comb begin
        step_ext     = {{(N+1-STEP_W){1'b0}}, step};
        sum_up       = {1'b0, counterN} + step_ext;
        lo_plus_step = {1'b0, limit_lo} + step_ext;
        wrap_up      = {2'b00, limit_lo} + ({1'b0, sum_up} - {2'b00, limit_hi} - ONE_N2);
        gap_dn       = lo_plus_step - {1'b0, counterN} - ONE_N1;
        wrap_dn      = {2'b00, limit_hi} - {1'b0, gap_dn};
        range_ok     = (limit_lo <= limit_hi);
    end

    always_comb begin
        cnt_next     = counterN;
        tc_next      = 1'b0;
        wrapped_next = 1'b0;
        if (!range_ok) begin
            cnt_next = counterN;
        end else if (step == '0) begin
            tc_next = dec ? (counterN == limit_lo) : (counterN == limit_hi);
        end else if (!dec) begin
            if (sum_up <= {1'b0, limit_hi}) begin
                cnt_next = sum_up[N-1:0];
                tc_next  = (sum_up[N-1:0] == limit_hi);
            end else if (sat_mode) begin
                cnt_next = limit_hi;
                tc_next  = 1'b1;
            end else begin
                cnt_next     = (wrap_up > {2'b00, limit_hi}) ? limit_lo : wrap_up[N-1:0];
                tc_next      = 1'b1;
                wrapped_next = 1'b1;
            end
        end else begin
            if ({1'b0, counterN} >= lo_plus_step) begin
                cnt_next = counterN - step_ext[N-1:0];
                tc_next  = (cnt_next == limit_lo);
            end else if (sat_mode) begin
                cnt_next = limit_lo;
                tc_next  = 1'b1;
            end else begin
                // Top bit set means the wrap distance exceeded limit_hi (borrow).
                if (wrap_dn[N+1] || (wrap_dn < {2'b00, limit_lo}))
                    cnt_next = limit_hi;
                else
                    cnt_next = wrap_dn[N-1:0];
                tc_next      = 1'b1;
                wrapped_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counterN <= '0;
            ref_reg  <= '0;
            tc       <= 1'b0;
            wrapped  <= 1'b0;
        end else begin
            if (ref_we)
                ref_reg <= ref_value;
            if (load) begin
                counterN <= load_value;
                tc       <= 1'b0;
                wrapped  <= 1'b0;
            end else if (enable) begin
                counterN <= cnt_next;
                tc       <= tc_next;
                wrapped  <= wrapped_next;
            end else begin
                tc       <= 1'b0;
                wrapped  <= 1'b0;
            end
        end
    end

    assign threshold = (counterN > ref_reg);

endmodule

// File: tb/tb_updown_range_counter.sv
// Directed bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_updown_range_counter;

    localparam int N      = 8;
    localparam int STEP_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              dec;
    logic              load;
    logic [N-1:0]      load_value;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      limit_lo;
    logic [N-1:0]      limit_hi;
    logic              sat_mode;
    logic              ref_we;
    logic [N-1:0]      ref_value;
    logic [N-1:0]      counterN;
    logic              threshold;
    logic              tc;
    logic              wrapped;

    typedef struct {
        string        name;
        logic [N-1:0] cnt;
        logic         thr;
        logic         tc;
        logic         wr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    updown_range_counter #(.N(N), .STEP_W(STEP_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .dec        (dec),
        .load       (load),
        .load_value (load_value),
        .step       (step),
        .limit_lo   (limit_lo),
        .limit_hi   (limit_hi),
        .sat_mode   (sat_mode),
        .ref_we     (ref_we),
        .ref_value  (ref_value),
        .counterN   (counterN),
        .threshold  (threshold),
        .tc         (tc),
        .wrapped    (wrapped)
    );

    // Inputs are set before the call; the edge that follows must produce the expectation.
    task automatic cyc(input string name, input int c, input bit thr, input bit t, input bit w);
        exp_t e;
        e.name = name;
        e.cnt  = c[N-1:0];
        e.thr  = thr;
        e.tc   = t;
        e.wr   = w;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic do_load(input string name, input int v, input bit thr);
        load = 1'b1; load_value = v[N-1:0];
        cyc(name, v, thr, 1'b0, 1'b0);
        load = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (counterN !== e.cnt) begin
                    bad++;
                    $display("FAIL %s counterN got=%0d want=%0d", e.name, counterN, e.cnt);
                end
                total++;
                if (threshold !== e.thr) begin
                    bad++;
                    $display("FAIL %s threshold got=%0b want=%0b", e.name, threshold, e.thr);
                end
                total++;
                if (tc !== e.tc) begin
                    bad++;
                    $display("FAIL %s tc got=%0b want=%0b", e.name, tc, e.tc);
                end
                total++;
                if (wrapped !== e.wr) begin
                    bad++;
                    $display("FAIL %s wrapped got=%0b want=%0b", e.name, wrapped, e.wr);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; dec = 1'b0; load = 1'b0; load_value = '0;
        step = '0; limit_lo = '0; limit_hi = 8'd255; sat_mode = 1'b0;
        ref_we = 1'b0; ref_value = '0;
        cyc("reset0", 0, 0, 0, 0);
        cyc("reset1", 0, 0, 0, 0);
        reset = 1'b0;

        // count to 37, then reset with enable held
        do_load("ld30", 30, 1);
        enable = 1'b1; step = 4'd7;
        cyc("up37", 37, 1, 0, 0);
        reset = 1'b1;
        cyc("rst_mid", 0, 0, 0, 0);
        reset = 1'b0; enable = 1'b0;

        // wrap mode, 10..20
        limit_lo = 8'd10; limit_hi = 8'd20; sat_mode = 1'b0; dec = 1'b0;
        do_load("ld18a", 18, 1);
        enable = 1'b1; step = 4'd2;
        cyc("up_hit_hi", 20, 1, 1, 0);
        enable = 1'b0;
        do_load("ld18b", 18, 1);
        enable = 1'b1; step = 4'd3;
        cyc("up_wrap", 10, 1, 1, 1);
        cyc("up_after_wrap", 13, 1, 0, 0);
        enable = 1'b0;

        // saturate down, 5..50
        limit_lo = 8'd5; limit_hi = 8'd50; sat_mode = 1'b1; dec = 1'b1;
        do_load("ld7a", 7, 1);
        enable = 1'b1; step = 4'd4;
        cyc("dn_sat", 5, 1, 1, 0);
        cyc("dn_sat_hold", 5, 1, 1, 0);
        step = 4'd0;
        cyc("step0_at_lo", 5, 1, 1, 0);
        enable = 1'b0;

        // wrap down, 5..50
        sat_mode = 1'b0; step = 4'd4;
        do_load("ld7b", 7, 1);
        enable = 1'b1;
        cyc("dn_wrap", 49, 1, 1, 1);
        enable = 1'b0;

        // saturate up, 10..20
        limit_lo = 8'd10; limit_hi = 8'd20; sat_mode = 1'b1; dec = 1'b0;
        do_load("ld18c", 18, 1);
        enable = 1'b1; step = 4'd5;
        cyc("up_sat", 20, 1, 1, 0);

        // load beats enable
        limit_lo = 8'd0; limit_hi = 8'd250; sat_mode = 1'b0;
        load = 1'b1; load_value = 8'd200;
        cyc("ld_over_en", 200, 1, 0, 0);
        load = 1'b0; step = 4'd1;
        cyc("up201", 201, 1, 0, 0);
        enable = 1'b0;

        // reference latched on the same edge as a load
        limit_hi = 8'd255;
        ref_we = 1'b1; ref_value = 8'd100;
        do_load("ld99_ref", 99, 0);
        ref_we = 1'b0;
        enable = 1'b1; step = 4'd1;
        cyc("thr_eq", 100, 0, 0, 0);
        cyc("thr_gt", 101, 1, 0, 0);
        enable = 1'b0;

        // invalid range holds
        limit_lo = 8'd30; limit_hi = 8'd20;
        do_load("ld25", 25, 0);
        enable = 1'b1; step = 4'd3;
        for (int i = 0; i < 4; i++) cyc("bad_range", 25, 0, 0, 0);
        enable = 1'b0;

        // step wider than the range, wrap up
        limit_lo = 8'd10; limit_hi = 8'd12; sat_mode = 1'b0; dec = 1'b0;
        do_load("ld11", 11, 0);
        enable = 1'b1; step = 4'd9;
        cyc("up_wrap_big", 10, 0, 1, 1);
        enable = 1'b0;

        // wrap distance exceeds limit_hi, wrap down
        limit_lo = 8'd2; limit_hi = 8'd3; dec = 1'b1;
        do_load("ld2", 2, 0);
        enable = 1'b1; step = 4'd15;
        cyc("dn_wrap_big", 3, 0, 1, 1);
        enable = 1'b0;

        // step 0, up, at and off the bound
        limit_lo = 8'd10; limit_hi = 8'd20; dec = 1'b0;
        do_load("ld20", 20, 0);
        enable = 1'b1; step = 4'd0;
        cyc("step0_at_hi", 20, 0, 1, 0);
        enable = 1'b0;
        do_load("ld15", 15, 0);
        enable = 1'b1;
        cyc("step0_mid", 15, 0, 0, 0);
        enable = 1'b0;
        cyc("idle", 15, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
